// File: rtl/pakesson_glitcher.sv
// UART-controlled glitch pulse generator: host sets delay/width, arms, and a trigger
// rising edge launches one pulse after the programmed delay. Also pulses a target reset.
module pakesson_glitcher #(
  parameter int CLK_HZ       = 50000000,
  parameter int BAUD         = 115200,
  parameter int RESET_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  // state | meaning: G_IDLE commands accepted | G_ARMED wait trigger edge
  //                  G_DELAY count delay      | G_PULSE drive pulse_out
  localparam int CPB = CLK_HZ / BAUD;
  localparam logic [15:0] BIT_TC  = 16'(CPB - 1);
  localparam logic [15:0] HALF_TC = 16'(CPB / 2 - 1);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam logic [RW-1:0] RST_TC = RW'(RESET_CYCLES - 1);
  localparam logic [7:0] CH_D = 8'h64, CH_W = 8'h77, CH_A = 8'h61, CH_R = 8'h72,
                         CH_X = 8'h78, CH_K = 8'h6B, CH_Q = 8'h3F, CH_G = 8'h47;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_e;
  typedef enum logic [1:0] {P_CMD, P_D_HI, P_D_LO, P_W} p_st_e;
  typedef enum logic [1:0] {G_IDLE, G_ARMED, G_DELAY, G_PULSE} g_st_e;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[5:0]};

  logic rx_s1_q, rx_s2_q, rx_prev_q, trig_s1_q, trig_s2_q, trig_prev_q, trig_edge;
  rx_st_e rx_st_q;
  logic [15:0] rx_cnt_q;
  logic [2:0] rx_idx_q;
  logic [7:0] rx_sh_q;
  logic rx_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_prev_q <= 1'b1;
      trig_s1_q <= 1'b0; trig_s2_q <= 1'b0; trig_prev_q <= 1'b0;
      rx_st_q <= RX_IDLE; rx_cnt_q <= '0; rx_idx_q <= '0; rx_sh_q <= '0; rx_valid_q <= 1'b0;
    end else begin
      rx_s1_q <= ui_in[7]; rx_s2_q <= rx_s1_q; rx_prev_q <= rx_s2_q;
      trig_s1_q <= ui_in[6]; trig_s2_q <= trig_s1_q; trig_prev_q <= trig_s2_q;
      rx_valid_q <= 1'b0;
      unique case (rx_st_q)
        RX_IDLE:
          if (rx_prev_q && !rx_s2_q) begin
            rx_st_q <= RX_START; rx_cnt_q <= HALF_TC;
          end
        RX_START:
          if (rx_cnt_q == '0) begin
            if (rx_s2_q) rx_st_q <= RX_IDLE;
            else begin
              rx_st_q <= RX_DATA; rx_cnt_q <= BIT_TC; rx_idx_q <= '0;
            end
          end else rx_cnt_q <= rx_cnt_q - 16'd1;
        RX_DATA:
          if (rx_cnt_q == '0) begin
            rx_sh_q <= {rx_s2_q, rx_sh_q[7:1]};
            rx_cnt_q <= BIT_TC;
            rx_idx_q <= rx_idx_q + 3'd1;
            if (rx_idx_q == 3'd7) rx_st_q <= RX_STOP;
          end else rx_cnt_q <= rx_cnt_q - 16'd1;
        default:
          if (rx_cnt_q == '0) begin
            rx_valid_q <= rx_s2_q;  // stop bit low: framing error, byte dropped
            rx_st_q <= RX_IDLE;
          end else rx_cnt_q <= rx_cnt_q - 16'd1;
      endcase
    end
  end
  assign trig_edge = trig_s2_q && !trig_prev_q;

  logic tx_req;
  logic [7:0] tx_req_byte, tx_buf_q;
  logic tx_pend_q;
  logic [9:0] tx_sh_q;
  logic [3:0] tx_bits_q;
  logic [15:0] tx_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_pend_q <= 1'b0; tx_buf_q <= '0; tx_sh_q <= '1; tx_bits_q <= '0; tx_cnt_q <= '0;
    end else begin
      if (tx_bits_q == '0) begin
        if (tx_pend_q) begin
          tx_sh_q <= {1'b1, tx_buf_q, 1'b0};
          tx_bits_q <= 4'd10; tx_cnt_q <= BIT_TC; tx_pend_q <= 1'b0;
        end
      end else if (tx_cnt_q == '0) begin
        tx_sh_q <= {1'b1, tx_sh_q[9:1]};
        tx_bits_q <= tx_bits_q - 4'd1; tx_cnt_q <= BIT_TC;
      end else tx_cnt_q <= tx_cnt_q - 16'd1;
      if (tx_req) begin
        tx_pend_q <= 1'b1; tx_buf_q <= tx_req_byte;
      end
    end
  end

  p_st_e p_st_q, p_st_d;
  g_st_e g_st_q, g_st_d;
  logic [15:0] delay_q, delay_d, g_cnt_q, g_cnt_d;
  logic [7:0] width_q, width_d, dhi_q, dhi_d;
  logic rst_act_q, rst_act_d, rst_start, rst_done, ack_k, ack_q, g_active, arm, abort, g_done;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic pulse_out, pulse_en;

  assign g_active = (g_st_q != G_IDLE);
  assign arm   = rx_valid_q && !g_active && (p_st_q == P_CMD) && (rx_sh_q == CH_A);
  assign abort = rx_valid_q && g_active && (rx_sh_q == CH_X);
  assign g_done = (g_st_q == G_PULSE) && (g_cnt_q == '0) && !abort;

  always_comb begin
    p_st_d = p_st_q; delay_d = delay_q; width_d = width_q; dhi_d = dhi_q;
    ack_k = 1'b0; ack_q = 1'b0; rst_start = 1'b0;
    if (rx_valid_q && !g_active) begin
      unique case (p_st_q)
        P_CMD:
          case (rx_sh_q)
            CH_D: p_st_d = P_D_HI;
            CH_W: p_st_d = P_W;
            CH_A, CH_X: ack_k = 1'b1;
            CH_R: rst_start = !rst_act_q;
            default: ack_q = 1'b1;
          endcase
        P_D_HI: begin dhi_d = rx_sh_q; p_st_d = P_D_LO; end
        P_D_LO: begin delay_d = {dhi_q, rx_sh_q}; p_st_d = P_CMD; ack_k = 1'b1; end
        default: begin
          width_d = (rx_sh_q == '0) ? 8'd1 : rx_sh_q;
          p_st_d = P_CMD; ack_k = 1'b1;
        end
      endcase
    end
    rst_act_d = rst_act_q; rst_cnt_d = rst_cnt_q; rst_done = 1'b0;
    if (rst_start) begin
      rst_act_d = 1'b1; rst_cnt_d = RST_TC;
    end else if (rst_act_q) begin
      if (rst_cnt_q == '0) begin rst_act_d = 1'b0; rst_done = 1'b1; end
      else rst_cnt_d = rst_cnt_q - RW'(1);
    end
    tx_req = ack_k || ack_q || abort || g_done || rst_done;
    tx_req_byte = ack_q ? CH_Q : (g_done ? CH_G : CH_K);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_st_q <= P_CMD; delay_q <= '0; width_q <= 8'd1; dhi_q <= '0;
      rst_act_q <= 1'b0; rst_cnt_q <= '0; g_st_q <= G_IDLE; g_cnt_q <= '0;
    end else begin
      p_st_q <= p_st_d; delay_q <= delay_d; width_q <= width_d; dhi_q <= dhi_d;
      rst_act_q <= rst_act_d; rst_cnt_q <= rst_cnt_d; g_st_q <= g_st_d; g_cnt_q <= g_cnt_d;
    end
  end

  // One down-counter serves both the delay and the pulse phases.
  always_comb begin
    g_st_d = g_st_q; g_cnt_d = g_cnt_q;
    unique case (g_st_q)
      G_IDLE: if (arm) g_st_d = G_ARMED;
      G_ARMED:
        if (abort) g_st_d = G_IDLE;
        else if (trig_edge) begin
          if (delay_q == '0) begin
            g_st_d = G_PULSE; g_cnt_d = {8'h00, width_q} - 16'd1;
          end else begin
            g_st_d = G_DELAY; g_cnt_d = delay_q - 16'd1;
          end
        end
      G_DELAY:
        if (abort) g_st_d = G_IDLE;
        else if (g_cnt_q == '0) begin
          g_st_d = G_PULSE; g_cnt_d = {8'h00, width_q} - 16'd1;
        end else g_cnt_d = g_cnt_q - 16'd1;
      default:
        if (abort || g_cnt_q == '0) g_st_d = G_IDLE;
        else g_cnt_d = g_cnt_q - 16'd1;
    endcase
  end

  always_comb begin
    pulse_en  = (g_st_q != G_IDLE);
    pulse_out = (g_st_q == G_PULSE);
  end

  assign uo_out  = {4'b0000, pulse_en, rst_act_q, pulse_out, tx_sh_q[0]};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
endmodule

// File: tb/tb_pakesson_glitcher.sv
// Scoreboard bench for pakesson_glitcher: stimulus pushes expected UART replies,
// pulse timing and target-reset widths; independent monitors pop and compare.
module tb_pakesson_glitcher;
  localparam int CPB = 10;
  localparam int RC  = 40;

  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic [7:0] ui_in = 8'h80, uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  pakesson_glitcher #(.CLK_HZ(1000000), .BAUD(100000), .RESET_CYCLES(RC)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe));

  always #5 clk = ~clk;

  int cyc = 0, checks = 0, errors = 0, tx_seen = 0;
  logic ignore_pulse = 1'b0;
  logic [7:0] exp_tx[$];
  int exp_ps[$], exp_pw[$], exp_rw[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // UART receiver on uart_tx
  initial begin : tx_mon
    logic [7:0] b, e;
    logic stop;
    forever begin
      @(negedge clk);
      if (rst_n && uo_out[0] == 1'b0) begin
        repeat (CPB / 2 - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uo_out[0];
        end
        repeat (CPB) @(negedge clk);
        stop = uo_out[0];
        tx_seen++;
        checks++;
        if (exp_tx.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected got=%02h want=none", b);
        end else begin
          e = exp_tx.pop_front();
          if (b !== e || stop !== 1'b1) begin
            errors++;
            $display("FAIL tx_byte got=%02h stop=%b want=%02h stop=1", b, stop, e);
          end
        end
      end
    end
  end

  initial begin : pulse_mon
    logic hi = 1'b0;
    int st = 0, w;
    forever begin
      @(negedge clk);
      if (uo_out[1] && !hi) begin hi = 1'b1; st = cyc; end
      else if (!uo_out[1] && hi) begin
        hi = 1'b0;
        w = cyc - st;
        if (!ignore_pulse) begin
          checks++;
          if (exp_ps.size() == 0) begin
            errors++;
            $display("FAIL pulse_unexpected start=%0d width=%0d want=none", st, w);
          end else begin
            int es, ew;
            es = exp_ps.pop_front(); ew = exp_pw.pop_front();
            if (st != es || w != ew) begin
              errors++;
              $display("FAIL pulse_timing start=%0d width=%0d want start=%0d width=%0d", st, w, es, ew);
            end
          end
        end
      end
    end
  end

  initial begin : rst_mon
    logic hi = 1'b0;
    int st = 0, w;
    forever begin
      @(negedge clk);
      if (uo_out[2] && !hi) begin hi = 1'b1; st = cyc; end
      else if (!uo_out[2] && hi) begin
        hi = 1'b0;
        w = cyc - st;
        checks++;
        if (exp_rw.size() == 0) begin
          errors++;
          $display("FAIL target_reset_unexpected width=%0d want=none", w);
        end else begin
          int ew;
          ew = exp_rw.pop_front();
          if (w != ew) begin
            errors++;
            $display("FAIL target_reset_width got=%0d want=%0d", w, ew);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    ui_in[7] = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ui_in[7] = b[i];
      repeat (CPB) @(negedge clk);
    end
    ui_in[7] = stop_bit;
    repeat (CPB) @(negedge clk);
    ui_in[7] = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] b, input logic [7:0] reply);
    exp_tx.push_back(reply);
    send_byte(b, 1'b1);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_tx.size() != 0 || exp_ps.size() != 0 || exp_rw.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_tx.size() != 0 || exp_ps.size() != 0 || exp_rw.size() != 0) begin
      errors++;
      $display("FAIL drain_%s pending tx=%0d pulse=%0d rst=%0d want=0", name,
               exp_tx.size(), exp_ps.size(), exp_rw.size());
    end
    repeat (CPB + 5) @(negedge clk);
  endtask

  task automatic fire(input int d, input int w);
    @(negedge clk);
    ui_in[6] = 1'b1;
    exp_ps.push_back(cyc + d + 3);
    exp_pw.push_back(w);
    exp_tx.push_back(8'h47);
  endtask

  task automatic trig_low();
    @(negedge clk);
    ui_in[6] = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (5) @(negedge clk);
    chk("reset_uo_out", uo_out, 8'h01);
    chk("reset_uio_oe", uio_oe, 8'h00);
    chk("reset_uio_out", uio_out, 8'h00);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("idle_tx_count", tx_seen, 0);
    chk("idle_uo_out", uo_out, 8'h01);

    // Configure delay=10, width=5 and fire
    cmd(8'h64, 8'h6B); send_byte(8'h00, 1'b1); send_byte(8'h0A, 1'b1);
    exp_tx.pop_back(); exp_tx.push_back(8'h6B);
    cmd(8'h77, 8'h6B); send_byte(8'h05, 1'b1);
    exp_tx.pop_back(); exp_tx.push_back(8'h6B);
    cmd(8'h61, 8'h6B);
    drain("config", 800);
    chk("armed_pulse_en", uo_out[3], 1'b1);
    fire(10, 5);
    drain("fire", 400);
    chk("post_fire_pulse_en", uo_out[3], 1'b0);

    // Zero delay and zero width (stored as 1)
    trig_low();
    cmd(8'h64, 8'h6B); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    exp_tx.pop_back(); exp_tx.push_back(8'h6B);
    cmd(8'h77, 8'h6B); send_byte(8'h00, 1'b1);
    exp_tx.pop_back(); exp_tx.push_back(8'h6B);
    cmd(8'h61, 8'h6B);
    drain("zero_cfg", 800);
    fire(0, 1);
    drain("zero_fire", 400);

    // Abort during a long delay; bytes other than 'x' are ignored while active
    trig_low();
    cmd(8'h64, 8'h6B); send_byte(8'hFF, 1'b1); send_byte(8'hFF, 1'b1);
    exp_tx.pop_back(); exp_tx.push_back(8'h6B);
    cmd(8'h61, 8'h6B);
    drain("abort_cfg", 600);
    send_byte(8'h7A, 1'b1);
    send_byte(8'h72, 1'b1);
    @(negedge clk);
    ui_in[6] = 1'b1;
    repeat (50) @(negedge clk);
    chk("delay_pulse_en", uo_out[3], 1'b1);
    cmd(8'h78, 8'h6B);
    drain("abort", 400);
    chk("abort_pulse_en", uo_out[3], 1'b0);
    chk("abort_pulse_out", uo_out[1], 1'b0);

    // Target reset, ignored repeat, unknown command
    exp_rw.push_back(RC);
    cmd(8'h72, 8'h6B);
    drain("target_reset", 400);
    cmd(8'h7A, 8'h3F);
    drain("unknown", 400);

    // Trigger while idle, then a frame with a bad stop bit
    trig_low();
    @(negedge clk); ui_in[6] = 1'b1;
    repeat (10) @(negedge clk); ui_in[6] = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_trigger_pulse_out", uo_out[1], 1'b0);
    n = tx_seen;
    send_byte(8'h78, 1'b0);
    repeat (200) @(negedge clk);
    chk("framing_error_no_reply", tx_seen, n);
    cmd(8'h78, 8'h6B);
    drain("after_framing", 400);

    // Async reset during a long pulse; configuration must reset
    cmd(8'h64, 8'h6B); send_byte(8'h00, 1'b1); send_byte(8'h03, 1'b1);
    exp_tx.pop_back(); exp_tx.push_back(8'h6B);
    cmd(8'h77, 8'h6B); send_byte(8'hC8, 1'b1);
    exp_tx.pop_back(); exp_tx.push_back(8'h6B);
    cmd(8'h61, 8'h6B);
    drain("mid_cfg", 800);
    ignore_pulse = 1'b1;
    @(negedge clk); ui_in[6] = 1'b1;
    n = 0;
    while (!uo_out[1] && n < 100) begin @(negedge clk); n++; end
    chk("mid_pulse_started", uo_out[1], 1'b1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_uo_out", uo_out, 8'h01);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ignore_pulse = 1'b0;
    repeat (10) @(negedge clk);

    // Trigger already high at arming must not fire; reset config gives delay 0, width 1
    cmd(8'h61, 8'h6B);
    drain("rearm", 400);
    repeat (30) @(negedge clk);
    chk("level_no_fire_pulse_en", uo_out[3], 1'b1);
    trig_low();
    fire(0, 1);
    drain("post_reset_fire", 400);
    chk("final_pulse_en", uo_out[3], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pakesson_glitcher.md
Name: pakesson_glitcher

Overview:
- UART-controlled fault-injection (glitch) pulse generator in Tiny Tapeout top-level wrapper form.
- Host configures delay and pulse width over UART, then arms the block.
- On a rising edge of the external trigger, the block waits the programmed delay and then drives one pulse of the programmed width.
- A separate command pulses a reset line to the target.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate for both directions. CLKS_PER_BIT = CLK_HZ/BAUD, integer division.
- RESET_CYCLES, 1000, number of clocks target_reset is held high per 'r' command.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  design-selected flag; ignored.
- ui_in  in  8  bit7 = uart_rx, bit6 = trigger_in; bits 5:0 unused.
- uo_out  out  8  bit0 = uart_tx, bit1 = pulse_out, bit2 = target_reset, bit3 = pulse_en; bits 7:4 = 0.
- uio_in  in  8  unused.
- uio_out  out  8  constant 0.
- uio_oe  out  8  constant 0 (all bidirectional pins are inputs).

Behaviour:
- Reset values:
  - uart_tx = 1; pulse_out, target_reset, pulse_en = 0.
  - delay register = 0 (16-bit); width register = 1 (8-bit).
  - FSM in IDLE; receive and transmit logic idle.
- UART format: 8N1, LSB first.
- UART RX:
  - Input passes through a 2-FF synchroniser.
  - A falling edge starts reception; the start bit is re-checked at mid-bit and the frame is dropped if it reads high.
  - Data bits are sampled at mid-bit.
  - If the stop bit samples as 0, the byte is discarded (framing error).
  - A valid byte produces a one-cycle rx_valid.
- UART TX:
  - Idle high.
  - Has a one-deep response register. Responses are only issued at command completion, so no overrun can occur at equal baud rates.
- Command parser (bytes are ASCII):
  - 'd' followed by 2 bytes, high byte first: set delay, ack 'k' (0x6B).
  - 'w' followed by 1 byte: set width, ack 'k'. A width of 0 is stored as 1.
  - 'a': arm, ack 'k', FSM goes to ARMED.
  - 'r': target_reset high for RESET_CYCLES clocks, starting the cycle after the byte is received; ack 'k' when the pulse ends.
  - 'x' in IDLE: ack 'k'.
  - Any other byte in IDLE: reply '?' (0x3F).
  - Argument bytes are taken raw and never interpreted as commands.
- Glitch FSM states: IDLE, ARMED, DELAY, PULSE.
  - pulse_en = 1 in ARMED, DELAY and PULSE; 0 otherwise.
  - Trigger input uses a 2-FF synchroniser and a rising-edge detector. Call E the cycle in which the synchronised edge is detected.
  - ARMED -> DELAY on the edge. Levels are ignored; a trigger that is already high when arming does not fire.
  - DELAY counts delay clocks.
  - pulse_out is high for exactly width cycles, from cycle E+delay+1 through E+delay+width inclusive. delay = 0 gives pulse_out high at E+1.
  - After PULSE the FSM returns to IDLE and transmits 'G' (0x47).
- While in ARMED, DELAY or PULSE:
  - 'x' aborts: pulse_out drops the next cycle, FSM goes to IDLE, ack 'k'.
  - All other bytes are ignored, with no reply.
  - Further trigger edges are ignored.
- 'r' while a glitch sequence is active is ignored.
- A new 'r' during an active target_reset pulse is ignored.
- Asynchronous reset mid-operation: all outputs return to their reset values immediately and configuration registers reset.

Test Plan:
- Reset: hold rst_n=0 -> uo_out = 0x01, uio_oe = 0x00; after release, no TX activity.
- Configure and fire:
  - Send 'd',0x00,0x0A, then 'w',0x05, then 'a' -> three 'k' replies; pulse_en=1.
  - Raise trigger_in -> pulse_out high for exactly 5 clocks, starting 11 clocks after cycle E; then pulse_en=0 and 'G' is transmitted.
- Zero settings: delay=0, width=0, armed, trigger -> 1-cycle pulse at E+1.
- Abort: arm with delay=0xFFFF, trigger, send 'x' during DELAY -> no pulse_out, 'k' reply, pulse_en=0.
- Target reset: send 'r' -> target_reset high exactly RESET_CYCLES clocks, then 'k'. Unknown byte 'z' -> '?' reply.
- Robustness:
  - Trigger pulse while not armed -> no pulse.
  - Frame with stop bit 0 -> no reply.
  - rst_n asserted during PULSE -> pulse_out=0 immediately.
